// File: rtl/morse_pkg.sv
// Shared types, constants and the A-Z / 0-9 Morse table for morse_tx.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StSpace,
    StGap,
    StFault
  } state_e;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam int unsigned NUM_CODES = 36;

  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_entry_t;

  // Element i is pattern[i], so each pattern reads as the Morse string reversed.
  function automatic morse_entry_t morse_lookup(input logic [31:0] code);
    morse_entry_t e;
    case (code)
      0:  e = {1'b1, 3'd2, 5'b00010};
      1:  e = {1'b1, 3'd4, 5'b00001};
      2:  e = {1'b1, 3'd4, 5'b00101};
      3:  e = {1'b1, 3'd3, 5'b00001};
      4:  e = {1'b1, 3'd1, 5'b00000};
      5:  e = {1'b1, 3'd4, 5'b00100};
      6:  e = {1'b1, 3'd3, 5'b00011};
      7:  e = {1'b1, 3'd4, 5'b00000};
      8:  e = {1'b1, 3'd2, 5'b00000};
      9:  e = {1'b1, 3'd4, 5'b01110};
      10: e = {1'b1, 3'd3, 5'b00101};
      11: e = {1'b1, 3'd4, 5'b00010};
      12: e = {1'b1, 3'd2, 5'b00011};
      13: e = {1'b1, 3'd2, 5'b00001};
      14: e = {1'b1, 3'd3, 5'b00111};
      15: e = {1'b1, 3'd4, 5'b00110};
      16: e = {1'b1, 3'd4, 5'b01011};
      17: e = {1'b1, 3'd3, 5'b00010};
      18: e = {1'b1, 3'd3, 5'b00000};
      19: e = {1'b1, 3'd1, 5'b00001};
      20: e = {1'b1, 3'd3, 5'b00100};
      21: e = {1'b1, 3'd4, 5'b01000};
      22: e = {1'b1, 3'd3, 5'b00110};
      23: e = {1'b1, 3'd4, 5'b01001};
      24: e = {1'b1, 3'd4, 5'b01101};
      25: e = {1'b1, 3'd4, 5'b00011};
      26: e = {1'b1, 3'd5, 5'b11111};
      27: e = {1'b1, 3'd5, 5'b11110};
      28: e = {1'b1, 3'd5, 5'b11100};
      29: e = {1'b1, 3'd5, 5'b11000};
      30: e = {1'b1, 3'd5, 5'b10000};
      31: e = {1'b1, 3'd5, 5'b00000};
      32: e = {1'b1, 3'd5, 5'b00001};
      33: e = {1'b1, 3'd5, 5'b00011};
      34: e = {1'b1, 3'd5, 5'b00111};
      35: e = {1'b1, 3'd5, 5'b01111};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Down-counter that times one or three Morse units; expire is high in the last cycle.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 25000000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic load,
  input  logic mult3,
  output logic expire
);

  localparam int unsigned CntW = $clog2(3 * UNIT_CYCLES);
  localparam logic [CntW-1:0] OneUnit   = CntW'(UNIT_CYCLES);
  localparam logic [CntW-1:0] ThreeUnit = CntW'(3 * UNIT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry at a count of 1 makes a load of N last exactly N cycles; zero is a resting value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = mult3 ? ThreeUnit : OneUnit;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CntW'(1));

endmodule

// File: rtl/morse_tx.sv
// Morse-code character transmitter with start/busy/done handshake.
// Define MORSE_TX_REPEAT_EN to add the repeat_en port for continuous repetition.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25000000,
  parameter int unsigned MAX_LEN     = 5,
  parameter int unsigned CODE_W      = 6
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic [CODE_W-1:0] char_code,
`ifdef MORSE_TX_REPEAT_EN
  input  logic              repeat_en,
`endif
  output logic              busy,
  output logic              done,
  output logic              invalid,
  output logic              led
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  state_e          state_q, state_d;
  logic [4:0]      pat_q, pat_d;
  logic [LenW-1:0] len_q, len_d;
  morse_entry_t    entry;
  logic            accept;
  logic            load, mult3, expire;

  assign entry  = morse_lookup(32'(char_code));
  assign accept = (state_q == StIdle) && start && entry.valid;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .load    (load),
    .mult3   (mult3),
    .expire  (expire)
  );

`ifdef MORSE_TX_REPEAT_EN
  logic [4:0]      first_pat_q;
  logic [LenW-1:0] first_len_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      first_pat_q <= '0;
      first_len_q <= '0;
    end else if (accept) begin
      first_pat_q <= entry.pattern;
      first_len_q <= LenW'(entry.len);
    end
  end
`endif

  // The timer is loaded on every state entry, with the duration of the state being entered.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    load    = 1'b0;
    mult3   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StMark;
          load    = 1'b1;
          mult3   = (entry.pattern[0] == DASH);
          pat_d   = entry.pattern;
          len_d   = LenW'(entry.len);
        end else if (start) begin
          state_d = StFault;
        end
      end
      StMark: begin
        if (expire) begin
          load = 1'b1;
          if (len_q > LenW'(1)) begin
            state_d = StSpace;
          end else begin
            state_d = StGap;
            mult3   = 1'b1;
          end
        end
      end
      StSpace: begin
        if (expire) begin
          state_d = StMark;
          load    = 1'b1;
          mult3   = (pat_q[1] == DASH);
          pat_d   = pat_q >> 1;
          len_d   = len_q - 1'b1;
        end
      end
      StGap: begin
        if (expire) begin
`ifdef MORSE_TX_REPEAT_EN
          if (repeat_en) begin
            state_d = StMark;
            load    = 1'b1;
            mult3   = (first_pat_q[0] == DASH);
            pat_d   = first_pat_q;
            len_d   = first_len_q;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
    end
  end

  // Outputs decode the registered state so a reset clears them without a clock edge.
  always_comb begin
    led     = (state_q == StMark);
    busy    = (state_q != StIdle);
    done    = ((state_q == StGap) && expire) || (state_q == StFault);
    invalid = (state_q == StFault);
  end

endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
Parametrised Morse-code transmitter. It drives a single LED/keying output with a full A–Z and 0–9 character set, standard ITU timing ratios, a programmable unit time, and a start/busy/done handshake. It sits between a character source (switches or an upstream controller) and a board LED or buzzer. It is the general-purpose replacement for the fixed 8-letter, 4-element Morse blinker.

Parameters:
- UNIT_CYCLES, default 25000000: clock cycles per Morse unit (0.5 s at 50 MHz); minimum 2.
- MAX_LEN, default 5: maximum elements per character; the table is sized for 5.
- CODE_W, default 6: width of the character code input.

Ports:
- CLOCK_50, input, 1: system clock, rising edge.
- resetn, input, 1: asynchronous active-low reset.
- start, input, 1: request to send char_code; sampled only in IDLE.
- char_code, input, CODE_W: 0–25 = A–Z, 26–35 = digits 0–9, 36 and above invalid.
- busy, output, 1: high from the cycle after start is accepted until the cycle after done.
- done, output, 1: one-cycle pulse at the end of a character (valid or invalid).
- invalid, output, 1: qualifies done; high in the done cycle if the code was out of range.
- led, output, 1: keying output; 1 = mark.
- repeat_en, input, 1: present only with MORSE_TX_REPEAT_EN (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state): state = IDLE, and led, busy, done and invalid are all 0. Timer and element counter are cleared. A reset mid-character aborts immediately; the LED drops without waiting for a clock edge.
- Timing: dot mark = 1 unit, dash mark = 3 units, inter-element space = 1 unit. After the last element there is a 3-unit character gap, with no extra element space first.
- Table: each entry is len (1..5) plus pattern[4:0]. Element i is pattern[i], sent LSB first; 0 = dot, 1 = dash.
- State machine:
  - IDLE: busy = 0. When start = 1, latch the code's len and pattern and go to MARK (or FAULT if the code is invalid).
  - MARK: led = 1 for exactly UNIT_CYCLES×(1 or 3) cycles. On expiry, if elements remain go to SPACE, otherwise go to GAP.
  - SPACE: led = 0 for UNIT_CYCLES cycles, then shift the pattern right, decrement the count, and go to MARK.
  - GAP: led = 0 for 3×UNIT_CYCLES cycles. done = 1 in the last cycle, then go to IDLE.
  - FAULT: one cycle; done = 1 and invalid = 1, led stays 0; then go to IDLE.
- Latency: if start is accepted at edge N, led and busy are high from edge N+1. Total busy time for a valid character = Σmarks + (len−1)×1 + 3 units.
- start while busy is ignored, with no queuing. char_code changes after acceptance do not affect the character in flight.
- start held high continuously: a new character begins the cycle after the busy-low cycle. IDLE lasts exactly one cycle.
- Timer: a down-counter of width $clog2(3×UNIT_CYCLES) loaded at each state entry. Expiry is when the count equals 1, so there is no off-by-one. It never wraps.

Optional Feature:
- Macro: MORSE_TX_REPEAT_EN.
- When defined, the repeat_en port exists. If repeat_en = 1 in the last GAP cycle, done still pulses, but the FSM reloads the latched code and goes straight to MARK; busy stays high. Deasserting repeat_en lets the current character finish normally.
- When not defined, the port is absent and GAP always returns to IDLE.

Decomposition:
- Package morse_pkg contains:
  - the state enum (IDLE, MARK, SPACE, GAP, FAULT);
  - the DOT = 0 and DASH = 1 constants;
  - NUM_CODES = 36;
  - a lookup function morse_lookup(code) returning {valid, len[2:0], pattern[4:0]}.
- Sub-module morse_unit_timer (parameter UNIT_CYCLES): load and multiplier inputs (1 or 3 units), expire output, cleared by resetn.

Test Plan (UNIT_CYCLES = 4, start pulsed at edge 0):
- Code 0 ('A', .-) -> led high on cycles 1–4, low 5–8, high 9–20, low 21–32; done at cycle 32; busy low at 33.
- Code 4 ('E', .) -> led high 1–4, low 5–16; done at 16; invalid = 0.
- Code 26 ('0', five dashes) -> 5 marks of 12 cycles, 4 spaces of 4, 12-cycle gap; done at cycle 88.
- Code 40 -> led never rises; done = 1 and invalid = 1 at cycle 1; busy low at cycle 2.
- Code 0 with resetn low at cycle 12 -> led, busy and done go to 0 asynchronously; a later start produces a full, correct 'A'.
- With MORSE_TX_REPEAT_EN and repeat_en = 1, code 4 -> done at 16, led rises again at 17, busy stays high; drop repeat_en -> second done at 32 and return to IDLE.
